// File: rtl/gfx_vram_wbuf.sv
// gfx_vram_wbuf: CPU-side VRAM write buffer and bus master.
//
// The CPU sets a 16-bit address and pushes data bytes through a 4-register
// control port. Each push queues {addr, data} in a FIFO. The FIFO drains into
// VRAM only while gfx_vga reports the video bus free (i_free_vbus_b low).
//
// Optional feature macro: GFX_VRAM_WBUF_AUTOINC_EN
//   defined   : reg 3 bit0 enables address auto-increment after each push
//   undefined : reg 3 writes are ignored
//
// Ports:
//   i_clk, i_rst_b        pixel clock, synchronous active-low reset
//   i_ctrl_ce_b/ce2/w_b   register select (low/high) and write strobe (low)
//   i_ctrl_addr[1:0]      0=addr lo, 1=addr hi, 2=data push, 3=control
//   i_ctrl_data[7:0]      register write data
//   i_free_vbus_b         low = video bus free for CPU writes
//   o_vaddr[15:0]         VRAM address while owning the bus
//   o_vaddr15_b           ~o_vaddr[15] (vram2 chip select)
//   o_vdata[7:0]          VRAM write data
//   o_bus_en_b            low = this block drives the addr/data buffers
//   o_vram_we_b           VRAM write enable, active low
//   o_full, o_empty       FIFO full / FIFO empty and no write in flight
//   o_overflow            sticky: push attempted while full
module gfx_vram_wbuf #(
  parameter int DEPTH     = 8,
  parameter int WE_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_b,
  input  logic        i_ctrl_ce_b,
  input  logic        i_ctrl_ce2,
  input  logic        i_ctrl_w_b,
  input  logic [1:0]  i_ctrl_addr,
  input  logic [7:0]  i_ctrl_data,
  input  logic        i_free_vbus_b,
  output logic [15:0] o_vaddr,
  output logic        o_vaddr15_b,
  output logic [7:0]  o_vdata,
  output logic        o_bus_en_b,
  output logic        o_vram_we_b,
  output logic        o_full,
  output logic        o_empty,
  output logic        o_overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int SW = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
  localparam logic [SW-1:0] STRB_LAST = SW'(WE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } state_t;

  state_t          state, state_d;
  logic [SW-1:0]   strb_cnt, strb_cnt_d;

  logic            w_b_q;
  logic            wr_evt;
  logic            push_req, push_ok, push_drop, pop;
  logic [15:0]     addr_q;
  logic [23:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr, head_idx;
  logic [CW-1:0]   count;
  logic            overflow_q;
  logic [15:0]     vaddr_q;
  logic [7:0]      vdata_q;
  logic            bus_en_b_q, we_b_q;

`ifdef GFX_VRAM_WBUF_AUTOINC_EN
  logic            autoinc_q;
`endif

  // Write event fires on the first cycle of a low w_b pulse only.
  assign wr_evt    = !i_ctrl_ce_b && i_ctrl_ce2 && !i_ctrl_w_b && w_b_q;
  assign push_req  = wr_evt && (i_ctrl_addr == 2'd2);
  assign pop       = (state == ST_HOLD);
  assign o_full    = (count == CW'(DEPTH));
  // A push while full is still accepted when the head leaves in the same cycle.
  assign push_ok   = push_req && (!o_full || pop);
  assign push_drop = push_req && o_full && !pop;

  // Leaving HOLD, rd_ptr advances on the same edge, so the next head is +1.
  assign head_idx  = (state == ST_HOLD) ? rd_ptr + AW'(1) : rd_ptr;

  always_comb begin
    state_d    = state;
    strb_cnt_d = strb_cnt;
    unique case (state)
      ST_IDLE: begin
        if ((count != '0) && !i_free_vbus_b) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        if (i_free_vbus_b) begin
          state_d = ST_IDLE;
        end else begin
          state_d    = ST_STROBE;
          strb_cnt_d = '0;
        end
      end
      ST_STROBE: begin
        if (i_free_vbus_b)              state_d = ST_IDLE;
        else if (strb_cnt == STRB_LAST) state_d = ST_HOLD;
        else                            strb_cnt_d = strb_cnt + SW'(1);
      end
      ST_HOLD: begin
        // Only entries already stored count; a same-cycle push waits in IDLE.
        if ((count > CW'(1)) && !i_free_vbus_b) state_d = ST_SETUP;
        else                                    state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wr_ptr] <= {addr_q, i_ctrl_data};
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_b) begin
      w_b_q      <= 1'b1;
      addr_q     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
      state      <= ST_IDLE;
      strb_cnt   <= '0;
      vaddr_q    <= '0;
      vdata_q    <= '0;
      bus_en_b_q <= 1'b1;
      we_b_q     <= 1'b1;
`ifdef GFX_VRAM_WBUF_AUTOINC_EN
      autoinc_q  <= 1'b0;
`endif
    end else begin
      w_b_q <= i_ctrl_w_b;

      if (wr_evt && (i_ctrl_addr == 2'd0)) addr_q[7:0]  <= i_ctrl_data;
      if (wr_evt && (i_ctrl_addr == 2'd1)) addr_q[15:8] <= i_ctrl_data;
`ifdef GFX_VRAM_WBUF_AUTOINC_EN
      if (wr_evt && (i_ctrl_addr == 2'd3)) autoinc_q <= i_ctrl_data[0];
      if (push_req && autoinc_q)           addr_q <= addr_q + 16'd1;
`endif

      if (push_ok)   wr_ptr     <= wr_ptr + AW'(1);
      if (pop)       rd_ptr     <= rd_ptr + AW'(1);
      if (push_drop) overflow_q <= 1'b1;
      count <= count + CW'(push_ok) - CW'(pop);

      state    <= state_d;
      strb_cnt <= strb_cnt_d;

      if (state_d == ST_SETUP) begin
        vaddr_q <= mem[head_idx][23:8];
        vdata_q <= mem[head_idx][7:0];
      end

      // Strobes are registered from the next state so they are glitch-free.
      bus_en_b_q <= (state_d == ST_IDLE);
      we_b_q     <= (state_d != ST_STROBE);
    end
  end

  assign o_vaddr     = vaddr_q;
  assign o_vaddr15_b = ~vaddr_q[15];
  assign o_vdata     = vdata_q;
  assign o_bus_en_b  = bus_en_b_q;
  assign o_vram_we_b = we_b_q;
  assign o_overflow  = overflow_q;
  assign o_empty     = (count == '0) && (state == ST_IDLE);

endmodule

// File: tb/tb_gfx_vram_wbuf.sv
module tb_gfx_vram_wbuf;

  localparam int DEPTH     = 8;
  localparam int WE_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        ctrl_ce_b, ctrl_ce2, ctrl_w_b;
  logic [1:0]  ctrl_addr;
  logic [7:0]  ctrl_data;
  logic        free_vbus_b;
  logic [15:0] vaddr;
  logic        vaddr15_b;
  logic [7:0]  vdata;
  logic        bus_en_b, vram_we_b, full, empty, overflow;

  gfx_vram_wbuf #(.DEPTH(DEPTH), .WE_CYCLES(WE_CYCLES)) dut (
    .i_clk(clk), .i_rst_b(rst_b),
    .i_ctrl_ce_b(ctrl_ce_b), .i_ctrl_ce2(ctrl_ce2), .i_ctrl_w_b(ctrl_w_b),
    .i_ctrl_addr(ctrl_addr), .i_ctrl_data(ctrl_data),
    .i_free_vbus_b(free_vbus_b),
    .o_vaddr(vaddr), .o_vaddr15_b(vaddr15_b), .o_vdata(vdata),
    .o_bus_en_b(bus_en_b), .o_vram_we_b(vram_we_b),
    .o_full(full), .o_empty(empty), .o_overflow(overflow)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model: CPU-visible registers plus the queue of VRAM writes owed.
  logic [15:0] addr_m = '0;
  logic        ainc_m = 1'b0;
  logic        ovf_m  = 1'b0;
  logic [23:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_apply(input logic [1:0] a, input logic [7:0] d);
    case (a)
      2'd0: addr_m[7:0]  = d;
      2'd1: addr_m[15:8] = d;
      2'd2: begin
        if (exp_q.size() >= DEPTH) ovf_m = 1'b1;
        else exp_q.push_back({addr_m, d});
`ifdef GFX_VRAM_WBUF_AUTOINC_EN
        if (ainc_m) addr_m = addr_m + 16'd1;
`endif
      end
      default: begin
`ifdef GFX_VRAM_WBUF_AUTOINC_EN
        ainc_m = d[0];
`endif
      end
    endcase
  endtask

  // Called #1 after a rising edge; returns #1 after the edge following the pulse.
  task automatic reg_write(input logic [1:0] a, input logic [7:0] d, input int unsigned len);
    ctrl_ce_b = 1'b0; ctrl_ce2 = 1'b1; ctrl_addr = a; ctrl_data = d; ctrl_w_b = 1'b0;
    model_apply(a, d);
    repeat (len) @(posedge clk);
    #1;
    ctrl_w_b = 1'b1; ctrl_ce_b = 1'b1; ctrl_ce2 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_empty(input int unsigned budget, output int unsigned n);
    n = 0;
    while (!empty && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_done", {31'd0, empty}, 32'd1);
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    tick(2);
    exp_q.delete();
    addr_m = '0; ainc_m = 1'b0; ovf_m = 1'b0;
    rst_b = 1'b1;
    tick(1);
  endtask

  // Monitor: a completed write is a WE_b low pulse ending with the bus still owned.
  initial begin : monitor
    logic        prev_we = 1'b1;
    int unsigned width = 0;
    logic [15:0] cap_a = '0;
    logic [7:0]  cap_d = '0;
    logic [23:0] e;
    forever begin
      @(negedge clk);
      if (prev_we && !vram_we_b) begin
        width = 1; cap_a = vaddr; cap_d = vdata;
        chk("strobe_bus_owned", {31'd0, bus_en_b}, 32'd0);
      end else if (!prev_we && !vram_we_b) begin
        width++;
        chk("strobe_addr_stable", {16'd0, vaddr}, {16'd0, cap_a});
        chk("strobe_data_stable", {24'd0, vdata}, {24'd0, cap_d});
      end else if (!prev_we && vram_we_b && !bus_en_b) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got %0h/%0h expected none", cap_a, cap_d);
        end else begin
          e = exp_q.pop_front();
          chk("write_addr", {16'd0, cap_a}, {16'd0, e[23:8]});
          chk("write_data", {24'd0, cap_d}, {24'd0, e[7:0]});
          chk("write_width", width, WE_CYCLES);
          chk("write_vaddr15_b", {31'd0, vaddr15_b}, {31'd0, ~e[23]});
        end
      end
      prev_we = vram_we_b;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int unsigned n;
    int unsigned op;
    ctrl_ce_b = 1'b1; ctrl_ce2 = 1'b0; ctrl_w_b = 1'b1;
    ctrl_addr = '0; ctrl_data = '0; free_vbus_b = 1'b1; rst_b = 1'b0;
    @(posedge clk); #1;
    do_reset();

    chk("rst_vaddr",     {16'd0, vaddr}, 32'd0);
    chk("rst_vaddr15_b", {31'd0, vaddr15_b}, 32'd1);
    chk("rst_vdata",     {24'd0, vdata}, 32'd0);
    chk("rst_bus_en_b",  {31'd0, bus_en_b}, 32'd1);
    chk("rst_we_b",      {31'd0, vram_we_b}, 32'd1);
    chk("rst_full",      {31'd0, full}, 32'd0);
    chk("rst_empty",     {31'd0, empty}, 32'd1);
    chk("rst_overflow",  {31'd0, overflow}, 32'd0);

    // Basic write: SETUP one clock after the push edge.
    free_vbus_b = 1'b0;
    reg_write(2'd0, 8'h34, 1);
    reg_write(2'd1, 8'h12, 1);
    reg_write(2'd2, 8'hAB, 1);
    chk("setup_bus_en_b", {31'd0, bus_en_b}, 32'd0);
    chk("setup_we_b",     {31'd0, vram_we_b}, 32'd1);
    chk("setup_vaddr",    {16'd0, vaddr}, 32'h1234);
    chk("setup_vdata",    {24'd0, vdata}, 32'hAB);
    chk("setup_vaddr15_b",{31'd0, vaddr15_b}, 32'd1);
    wait_empty(50, n);
    chk("basic_queue_drained", exp_q.size(), 0);

    // Fill while busy, overflow, then timed drain.
    free_vbus_b = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      reg_write(2'd0, 8'($urandom), 1);
      reg_write(2'd1, 8'($urandom), 1);
      reg_write(2'd2, 8'($urandom), 1);
    end
    chk("fill_full",     {31'd0, full}, 32'd1);
    chk("fill_no_ovf",   {31'd0, overflow}, 32'd0);
    reg_write(2'd2, 8'h5A, 1);
    chk("ovf_set",       {31'd0, overflow}, {31'd0, ovf_m});
    chk("ovf_full",      {31'd0, full}, 32'd1);
    free_vbus_b = 1'b0;
    wait_empty(200, n);
    chk("drain_cycles", n, DEPTH * (WE_CYCLES + 2) + 1);
    chk("ovf_sticky",    {31'd0, overflow}, 32'd1);
    chk("drain_queue",   exp_q.size(), 0);

    // Abort during the first STROBE clock, then retry.
    free_vbus_b = 1'b1;
    reg_write(2'd0, 8'hC3, 1);
    reg_write(2'd1, 8'h9E, 1);
    reg_write(2'd2, 8'h77, 1);
    reg_write(2'd2, 8'h78, 1);
    free_vbus_b = 1'b0;
    tick(2);
    chk("abort_strobe_we_b", {31'd0, vram_we_b}, 32'd0);
    free_vbus_b = 1'b1;
    tick(1);
    chk("abort_we_b",     {31'd0, vram_we_b}, 32'd1);
    chk("abort_bus_en_b", {31'd0, bus_en_b}, 32'd1);
    chk("abort_not_empty",{31'd0, empty}, 32'd0);
    chk("abort_queue",    exp_q.size(), 2);
    tick(3);
    free_vbus_b = 1'b0;
    wait_empty(100, n);
    chk("abort_queue_drained", exp_q.size(), 0);

    // Long pulse pushes once; separate pulses push separately.
    free_vbus_b = 1'b1;
    reg_write(2'd2, 8'h01, 5);
    reg_write(2'd2, 8'h02, 1);
    reg_write(2'd2, 8'h03, 1);
    chk("pulse_not_empty", {31'd0, empty}, 32'd0);
    chk("pulse_not_full",  {31'd0, full}, 32'd0);
    free_vbus_b = 1'b0;
    wait_empty(100, n);
    chk("pulse_queue_drained", exp_q.size(), 0);

    // Reset in the middle of STROBE.
    free_vbus_b = 1'b1;
    reg_write(2'd2, 8'hEE, 1);
    reg_write(2'd2, 8'hEF, 1);
    free_vbus_b = 1'b0;
    tick(2);
    chk("rst_mid_strobe_we_b", {31'd0, vram_we_b}, 32'd0);
    rst_b = 1'b0;
    tick(1);
    chk("rst_mid_we_b",     {31'd0, vram_we_b}, 32'd1);
    chk("rst_mid_bus_en_b", {31'd0, bus_en_b}, 32'd1);
    chk("rst_mid_empty",    {31'd0, empty}, 32'd1);
    chk("rst_mid_overflow", {31'd0, overflow}, 32'd0);
    exp_q.delete();
    addr_m = '0; ainc_m = 1'b0; ovf_m = 1'b0;
    rst_b = 1'b1;
    tick(5);
    chk("rst_mid_stays_empty", {31'd0, empty}, 32'd1);

`ifdef GFX_VRAM_WBUF_AUTOINC_EN
    // Auto-increment wraps 0xFFFF -> 0x0000.
    free_vbus_b = 1'b1;
    reg_write(2'd3, 8'h01, 1);
    reg_write(2'd0, 8'hFF, 1);
    reg_write(2'd1, 8'hFF, 1);
    reg_write(2'd2, 8'h11, 1);
    reg_write(2'd2, 8'h22, 1);
    chk("ainc_model_wrap", exp_q[1][23:8], 32'h0000);
    free_vbus_b = 1'b0;
    wait_empty(100, n);
    chk("ainc_queue_drained", exp_q.size(), 0);
`endif

    // Randomized traffic with random bus availability.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) free_vbus_b = ~free_vbus_b;
      op = $urandom_range(0, 3);
      if (op == 2 && exp_q.size() > DEPTH - 3) op = 0;
      reg_write(2'(op), 8'($urandom), $urandom_range(1, 3));
      if ($urandom_range(0, 1) == 1) tick($urandom_range(1, 3));
    end
    free_vbus_b = 1'b0;
    wait_empty(500, n);
    chk("rand_queue_drained", exp_q.size(), 0);
    chk("rand_overflow",      {31'd0, overflow}, {31'd0, ovf_m});
    chk("rand_full",          {31'd0, full}, 32'd0);

    tick(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
